// File: rtl/lockin_pkg.sv
// -----------------------------------------------------------------------------
// lockin_pkg
//
// Shared definitions for the lock-in magnitude/phase CORDIC stage.
//
// Contents:
//   state_t            FSM state encoding of lockin_mag_fase
//   ATAN[0:31]         CORDIC angle table, round(atan(2^-i) * 2^31 / pi),
//                      expressed as 32-bit binary angles (2^31 == pi)
//   K_INV              inverse CORDIC gain, Q1.31 (~0.607253)
//   ANG_PI_HALF        +pi/2 as a 32-bit binary angle (pre-rotation)
//   ANG_MINUS_PI_HALF  -pi/2 as a 32-bit binary angle (pre-rotation)
//
// The angle constants are stored at 32 bits; the datapath rescales them to
// its own width W.
// -----------------------------------------------------------------------------
package lockin_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_PREROT = 3'd1,
        ST_ITER   = 3'd2,
        ST_COMP   = 3'd3,
        ST_OUT    = 3'd4
    } state_t;

    localparam logic [31:0] ATAN [0:31] = '{
        32'h2000_0000, 32'h12E4_051E, 32'h09FB_385B, 32'h0511_11D4,
        32'h028B_0D43, 32'h0145_D7E1, 32'h00A2_F61E, 32'h0051_7C55,
        32'h0028_BE53, 32'h0014_5F2F, 32'h000A_2F98, 32'h0005_17CC,
        32'h0002_8BE6, 32'h0001_45F3, 32'h0000_A2FA, 32'h0000_517D,
        32'h0000_28BE, 32'h0000_145F, 32'h0000_0A30, 32'h0000_0518,
        32'h0000_028C, 32'h0000_0146, 32'h0000_00A3, 32'h0000_0051,
        32'h0000_0029, 32'h0000_0014, 32'h0000_000A, 32'h0000_0005,
        32'h0000_0003, 32'h0000_0001, 32'h0000_0001, 32'h0000_0000
    };

    localparam logic [31:0] K_INV             = 32'h4DBA_76D4;
    localparam logic [31:0] ANG_PI_HALF       = 32'h4000_0000;
    localparam logic [31:0] ANG_MINUS_PI_HALF = 32'hC000_0000;

endpackage

// File: rtl/lockin_mag_fase.sv
// -----------------------------------------------------------------------------
// lockin_mag_fase
//
// Iterative CORDIC vectoring stage behind the lock-in demodulator. Converts an
// in-phase/quadrature pair into magnitude and phase, one micro-rotation per
// clock. A one-deep pending register catches a pair that arrives while a
// computation is in flight; anything beyond that is dropped and flagged.
//
// Parameters:
//   N_ITER  number of micro-rotations (1..31, limited by the ATAN table)
//   W       input/output data width
//
// Ports:
//   clock            rising-edge clock
//   reset            synchronous, active-high
//   data_fase        I sample (signed)
//   data_valid_fase  I strobe
//   data_cuad        Q sample (signed)
//   data_valid_cuad  Q strobe; a pair is taken only when both strobes are high
//   clear_ovr        clears the sticky overrun flag (a same-cycle set wins)
//   mag_out          magnitude (unsigned, saturated to 2^W-1)
//   fase_out         phase as a binary angle, 2^(W-1) == pi
//   data_valid       one-cycle strobe when mag_out/fase_out update
//   busy             high whenever the FSM is not idle
//   overrun          sticky: a pending pair was discarded
//
// Configuration:
//   LOCKIN_MAG_GAIN_COMP_EN  when defined, an extra COMP state multiplies x by
//                            K_INV so mag_out approximates the true magnitude.
//                            When undefined, mag_out is the raw CORDIC x
//                            (~1.64676 * |v|) and latency is one cycle shorter.
// -----------------------------------------------------------------------------
module lockin_mag_fase
    import lockin_pkg::*;
#(
    parameter int N_ITER = 16,
    parameter int W      = 32
) (
    input  logic                clock,
    input  logic                reset,
    input  logic signed [W-1:0] data_fase,
    input  logic                data_valid_fase,
    input  logic signed [W-1:0] data_cuad,
    input  logic                data_valid_cuad,
    input  logic                clear_ovr,
    output logic        [W-1:0] mag_out,
    output logic signed [W-1:0] fase_out,
    output logic                data_valid,
    output logic                busy,
    output logic                overrun
);

    // Three guard bits: one for the CORDIC gain (~1.65), one for the sqrt(2)
    // of a full-scale diagonal input, one for negating -2^(W-1).
    localparam int XW = W + 3;

    // Rescale a 32-bit binary angle to W bits (a * 2^W / 2^32).
    function automatic logic [W-1:0] scale_ang(input logic [31:0] a);
        return W'({a, {W{1'b0}}} >> 32);
    endfunction

    // Clamp the internal x to the unsigned output range.
    function automatic logic [W-1:0] sat_mag(input logic signed [XW-1:0] v);
        if (v[XW-1]) begin
            return '0;
        end else if (|v[XW-2:W]) begin
            return '1;
        end else begin
            return v[W-1:0];
        end
    endfunction

    localparam logic [W-1:0] Z_PI_HALF       = scale_ang(ANG_PI_HALF);
    localparam logic [W-1:0] Z_MINUS_PI_HALF = scale_ang(ANG_MINUS_PI_HALF);

`ifdef LOCKIN_MAG_GAIN_COMP_EN
    localparam state_t ST_AFTER_ITER = ST_COMP;
`else
    localparam state_t ST_AFTER_ITER = ST_OUT;
`endif

    state_t state;
    state_t state_nxt;

    // CORDIC datapath
    logic signed [XW-1:0] x;
    logic signed [XW-1:0] y;
    logic        [W-1:0]  z;
    logic        [4:0]    iter;
    logic        [W-1:0]  atan_i;
    logic                 zero_in;

    // One-deep pending buffer
    logic                 pend_valid;
    logic signed [W-1:0]  pend_fase;
    logic signed [W-1:0]  pend_cuad;

    logic pair_in;
    logic last_iter;
    logic ovr_set;

    assign pair_in   = data_valid_fase & data_valid_cuad;
    assign last_iter = (iter == 5'(N_ITER - 1));
    assign atan_i    = scale_ang(ATAN[iter]);
    assign busy      = (state != ST_IDLE);

    // A fresh pair meeting a held pair always costs one of them: in IDLE the
    // held pair is dropped in favour of the new one, otherwise the held pair
    // is overwritten. Either way the loss is flagged.
    assign ovr_set = pair_in & pend_valid;

`ifdef LOCKIN_MAG_GAIN_COMP_EN
    // (x * K_INV) >>> 31; K_INV < 1 so the result always fits back in XW bits.
    logic signed [XW-1:0] x_comp;
    assign x_comp = XW'(((XW + 33)'(x) * (XW + 33)'($signed({1'b0, K_INV}))) >>> 31);
`endif

    // -------------------------------------------------------------------------
    // FSM
    // -------------------------------------------------------------------------
    // NOTE: state and all registered values use non-blocking assignments so
    // every flop samples the pre-edge values regardless of statement order.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: state_nxt is given a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE: begin
                if (pair_in || pend_valid) begin
                    state_nxt = ST_PREROT;
                end
            end
            ST_PREROT: state_nxt = ST_ITER;
            ST_ITER: begin
                if (last_iter) begin
                    state_nxt = ST_AFTER_ITER;
                end
            end
            ST_COMP:  state_nxt = ST_OUT;
            ST_OUT:   state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // CORDIC datapath
    // -------------------------------------------------------------------------
    // NOTE: the datapath registers carry no reset; each computation loads x/y
    // in IDLE and z/iter in PREROT before anything reads them.
    always_ff @(posedge clock) begin
        case (state)
            ST_IDLE: begin
                if (pair_in) begin
                    x <= {{3{data_fase[W-1]}}, data_fase};
                    y <= {{3{data_cuad[W-1]}}, data_cuad};
                end else if (pend_valid) begin
                    x <= {{3{pend_fase[W-1]}}, pend_fase};
                    y <= {{3{pend_cuad[W-1]}}, pend_cuad};
                end
            end
            ST_PREROT: begin
                // A zero vector would otherwise rotate the full ATAN sum into
                // z; remember it so the reported phase is 0.
                zero_in <= (x == '0) && (y == '0);
                iter    <= '0;
                if (!x[XW-1]) begin
                    z <= '0;
                end else if (!y[XW-1]) begin
                    x <= y;
                    y <= -x;
                    z <= Z_PI_HALF;
                end else begin
                    x <= -y;
                    y <= x;
                    z <= Z_MINUS_PI_HALF;
                end
            end
            ST_ITER: begin
                iter <= iter + 5'd1;
                if (!y[XW-1]) begin
                    x <= x + (y >>> iter);
                    y <= y - (x >>> iter);
                    z <= z + atan_i;
                end else begin
                    x <= x - (y >>> iter);
                    y <= y + (x >>> iter);
                    z <= z - atan_i;
                end
            end
`ifdef LOCKIN_MAG_GAIN_COMP_EN
            ST_COMP: begin
                x <= x_comp;
            end
`endif
            default: begin
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Pending buffer
    // -------------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            pend_valid <= 1'b0;
        end else if (state == ST_IDLE) begin
            // IDLE either consumes the held pair or drops it for a fresh one.
            pend_valid <= 1'b0;
        end else if (pair_in) begin
            pend_valid <= 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (pair_in && (state != ST_IDLE)) begin
            pend_fase <= data_fase;
            pend_cuad <= data_cuad;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs and overrun flag
    // -------------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            mag_out    <= '0;
            fase_out   <= '0;
            data_valid <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            data_valid <= (state == ST_OUT);
            if (state == ST_OUT) begin
                mag_out  <= sat_mag(x);
                fase_out <= zero_in ? '0 : z;
            end
            if (ovr_set) begin
                overrun <= 1'b1;
            end else if (clear_ovr) begin
                overrun <= 1'b0;
            end
        end
    end

endmodule
